signed_sum_accum: RTL and testbench
===================================

SIGNED_SUM_ACCUM -- requirements
Module: signed_sum_accum

Interface
REQ-001 SHALL provide parameter ACC_W, default 8, accumulator width in bits (legal range 6..32).
REQ-002 SHALL provide parameter FRAME_LEN, default 4, number of input beats per frame (legal range 1..255).
REQ-003 SHALL provide clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL provide rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide in_valid  input  1  upstream sum beat is present.
REQ-006 SHALL provide in_ready  output  1  the block accepts a beat this cycle.
REQ-007 SHALL provide in_sum  input  5  two's-complement sum from the 4-bit signed adder stage (range -16..+15).
REQ-008 SHALL provide in_ovf  input  1  adder overflow flag accompanying in_sum.
REQ-009 SHALL provide flush  input  1  close the current frame early.
REQ-010 SHALL provide out_valid  output  1  a frame result is presented.
REQ-011 SHALL provide out_ready  input  1  downstream accepts the result.
REQ-012 SHALL provide out_acc  output  ACC_W  signed, saturated frame total.
REQ-013 SHALL provide out_count  output  8  number of beats in the frame.
REQ-014 SHALL provide out_sat  output  1  saturation occurred within the frame.
REQ-015 SHALL provide out_ovf  output  1  in_ovf was high on at least one accepted beat of the frame.

Function
REQ-016 A beat SHALL be accepted only when in_valid and in_ready are both high on a rising edge.
REQ-017 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-018 In IDLE and ACCUM, in_ready SHALL be 1; in DONE, in_ready SHALL be 0.
REQ-019 Accepting a beat in IDLE SHALL load acc to sext(in_sum), set count to 1 and clear the sticky flags before applying the beat.
REQ-020 Accepting a beat in ACCUM SHALL set acc to sat(acc + sext(in_sum)), computed at ACC_W+1 bits, and SHALL increment count.
REQ-021 Saturation SHALL clamp the result to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and SHALL set sticky out_sat.
REQ-022 in_ovf on any accepted beat SHALL set sticky out_ovf; it SHALL NOT alter acc.
REQ-023 When an accepted beat makes count equal FRAME_LEN, the FSM SHALL go to DONE; with FRAME_LEN=1 this applies from IDLE.
REQ-024 flush high in ACCUM SHALL move the FSM to DONE; a beat accepted in the same cycle SHALL be included first.
REQ-025 flush in IDLE SHALL move the FSM to DONE only if a beat is accepted in the same cycle (count=1); otherwise it SHALL be ignored. flush in DONE SHALL be ignored.
REQ-026 In DONE, out_valid SHALL be 1 and out_acc, out_count, out_sat and out_ovf SHALL be registered and held stable until out_ready is high.
REQ-027 out_valid SHALL rise on the cycle after the closing beat is accepted (latency 1); out_valid && out_ready SHALL return the FSM to IDLE.
REQ-028 Throughput SHALL be FRAME_LEN beats plus one handshake cycle per frame; there is no output buffering.

Reset
REQ-029 rst SHALL immediately force IDLE and clear acc, count, out_acc, out_count, out_sat, out_ovf and out_valid to 0, with in_ready=1 after release.
REQ-030 A partial frame interrupted by rst SHALL be discarded and no result emitted.

Structure
REQ-031 Package signed_acc_pkg SHALL hold the state encoding (IDLE=0, ACCUM=1, DONE=2) and the default ACC_W and FRAME_LEN constants.
REQ-032 Saturating addition SHALL be a combinational sub-module sat_add (parameter W) with outputs sum and sat; the top level instantiates it once.

Verification (ACC_W=8, FRAME_LEN=4 unless noted)
REQ-033 Sums 3,-5,7,1 on consecutive cycles -> out_valid on the cycle after the 4th accept, out_acc=6, out_count=4, out_sat=0, out_ovf=0.
REQ-034 ACC_W=6, sums 14,14,14,14 -> out_acc=31, out_sat=1; sums -16 x4 -> out_acc=-32, out_sat=1.
REQ-035 out_ready held low for 5 cycles in DONE -> outputs stable, in_ready=0, no in_valid beat consumed; on the out_ready pulse -> IDLE, and the next beat starts a new frame.
REQ-036 Sums 2,-1 with flush on the 2nd beat -> out_acc=1, out_count=2.
REQ-037 rst asserted after 2 beats -> all outputs 0 immediately; next frame 1,1,1,1 -> out_acc=4.
REQ-038 in_ovf=1 on beat 2 of 5,5,5,5 -> out_ovf=1, out_acc=20.

Source files
------------

// File: rtl/signed_acc_pkg.sv
// rtl/signed_acc_pkg.sv - shared state encoding and default parameters
package signed_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_ACC_W     = 8;
  localparam int DEF_FRAME_LEN = 4;

endpackage

// File: rtl/signed_sum_accum_if.sv
// rtl/signed_sum_accum_if.sv - beat input / frame result handshake bundle
interface signed_sum_accum_if
  import signed_acc_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_sum;
  logic             in_ovf;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [7:0]       out_count;
  logic             out_sat;
  logic             out_ovf;

  modport master (
    output in_valid, in_sum, in_ovf, flush, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_sat, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, in_ovf, flush, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_sat, out_ovf
  );
endinterface

// File: rtl/signed_sum_accum_sat_add.sv
// rtl/signed_sum_accum_sat_add.sv - combinational W-bit signed add clamped to range
module sat_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);
  logic [W:0] wide;

  assign wide = {a[W-1], a} + {b[W-1], b};

  // Overflow shows up as disagreement between the guard bit and the W-bit sign.
  always_comb begin
    sum = wide[W-1:0];
    sat = 1'b0;
    if (wide[W] != wide[W-1]) begin
      sat = 1'b1;
      sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
endmodule

// File: rtl/signed_sum_accum.sv
// rtl/signed_sum_accum.sv - frames signed adder sums into a saturated total with sticky flags
module signed_sum_accum
  import signed_acc_pkg::*;
#(
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input logic               clk,
  input logic               rst,
  signed_sum_accum_if.slave bus
);
  localparam logic [7:0] LAST = 8'(FRAME_LEN);

  state_t           state;
  state_t           state_nx;
  logic [ACC_W-1:0] acc;
  logic [7:0]       count;
  logic             sat_st;
  logic             ovf_st;
  logic             accept;
  logic [ACC_W-1:0] beat_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_sat;

  assign accept   = bus.in_valid && bus.in_ready;
  assign beat_ext = {{(ACC_W-5){bus.in_sum[4]}}, bus.in_sum};

  sat_add #(.W(ACC_W)) u_sat_add (
    .a  (acc),
    .b  (beat_ext),
    .sum(add_sum),
    .sat(add_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept && (LAST == 8'd1 || bus.flush)) state_nx = DONE;
        else if (accept)                          state_nx = ACCUM;
      end
      ACCUM: begin
        // Flush alone closes the frame; a beat in the same cycle is folded in first.
        if (bus.flush || (accept && (count + 8'd1) == LAST)) state_nx = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state != DONE);
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      count  <= '0;
      sat_st <= 1'b0;
      ovf_st <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        acc    <= beat_ext;
        count  <= 8'd1;
        sat_st <= 1'b0;
        ovf_st <= bus.in_ovf;
      end else begin
        acc    <= add_sum;
        count  <= count + 8'd1;
        sat_st <= sat_st | add_sat;
        ovf_st <= ovf_st | bus.in_ovf;
      end
    end
  end

  // Totals are only touched on accepted beats, so they stay frozen throughout DONE.
  assign bus.out_acc   = acc;
  assign bus.out_count = count;
  assign bus.out_sat   = sat_st;
  assign bus.out_ovf   = ovf_st;
endmodule

// File: tb/tb_signed_sum_accum.sv
// tb/tb_signed_sum_accum.sv - directed table-driven bench for signed_sum_accum (ACC_W 8 and 6)
module tb_signed_sum_accum;
  import signed_acc_pkg::*;

  typedef struct {
    int             n;
    logic [3:0][4:0] s;
    logic [3:0]     ovf;
    bit             fl;
    int             e8;
    int             e6;
    bit             s8;
    bit             s6;
    bit             eo;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl [12];

  signed_sum_accum_if #(.ACC_W(8)) b8 ();
  signed_sum_accum_if #(.ACC_W(6)) b6 ();

  assign b6.in_valid  = b8.in_valid;
  assign b6.in_sum    = b8.in_sum;
  assign b6.in_ovf    = b8.in_ovf;
  assign b6.flush     = b8.flush;
  assign b6.out_ready = b8.out_ready;

  signed_sum_accum #(.ACC_W(8), .FRAME_LEN(4)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  signed_sum_accum #(.ACC_W(6), .FRAME_LEN(4)) dut6 (.clk(clk), .rst(rst), .bus(b6));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input int a0, input int a1, input int a2, input int a3,
                              input logic [3:0] ovf, input bit fl, input int e8, input int e6,
                              input bit s8, input bit s6, input bit eo);
    vec_t v;
    v.n = n;
    v.s[0] = 5'(a0);
    v.s[1] = 5'(a1);
    v.s[2] = 5'(a2);
    v.s[3] = 5'(a3);
    v.ovf = ovf;
    v.fl = fl;
    v.e8 = e8;
    v.e6 = e6;
    v.s8 = s8;
    v.s6 = s6;
    v.eo = eo;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx, input int hold);
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      if (i == 0) check($sformatf("v%0d_in_ready", idx), int'(b8.in_ready), 1);
      b8.in_valid = 1'b1;
      b8.in_sum   = v.s[i];
      b8.in_ovf   = v.ovf[i];
      b8.flush    = v.fl && (i == v.n - 1);
      @(posedge clk);
    end
    #1;
    check($sformatf("v%0d_valid_lat1", idx), int'(b8.out_valid), 1);
    @(negedge clk);
    b8.in_valid = 1'b0;
    b8.flush    = 1'b0;
    b8.in_ovf   = 1'b0;
    check($sformatf("v%0d_acc8", idx), $signed(b8.out_acc), v.e8);
    check($sformatf("v%0d_acc6", idx), $signed(b6.out_acc), v.e6);
    check($sformatf("v%0d_count", idx), int'(b8.out_count), v.n);
    check($sformatf("v%0d_sat8", idx), int'(b8.out_sat), int'(v.s8));
    check($sformatf("v%0d_sat6", idx), int'(b6.out_sat), int'(v.s6));
    check($sformatf("v%0d_ovf", idx), int'(b8.out_ovf), int'(v.eo));
    for (int h = 0; h < hold; h++) begin
      b8.in_valid = 1'b1;
      b8.in_sum   = 5'd9;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_hold%0d_valid", idx, h), int'(b8.out_valid), 1);
      check($sformatf("v%0d_hold%0d_in_ready", idx, h), int'(b8.in_ready), 0);
      check($sformatf("v%0d_hold%0d_acc8", idx, h), $signed(b8.out_acc), v.e8);
      check($sformatf("v%0d_hold%0d_count", idx, h), int'(b8.out_count), v.n);
      @(negedge clk);
    end
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check($sformatf("v%0d_valid_drop", idx), int'(b8.out_valid), 0);
    b8.out_ready = 1'b0;
  endtask

  initial begin
    b8.in_valid  = 1'b0;
    b8.in_sum    = 5'd0;
    b8.in_ovf    = 1'b0;
    b8.flush     = 1'b0;
    b8.out_ready = 1'b0;

    tbl[0]  = mk(4,   3,  -5,   7,   1, 4'b0000, 1'b0,   6,   6, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(4,   5,   5,   5,   5, 4'b0010, 1'b0,  20,  20, 1'b0, 1'b0, 1'b1);
    tbl[2]  = mk(2,   2,  -1,   0,   0, 4'b0000, 1'b1,   1,   1, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(4,  14,  14,  14,  14, 4'b0000, 1'b0,  56,  31, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(4, -16, -16, -16, -16, 4'b0000, 1'b0, -64, -32, 1'b0, 1'b1, 1'b0);
    tbl[5]  = mk(4,  15,  15,   2, -16, 4'b0000, 1'b0,  16,  15, 1'b0, 1'b1, 1'b0);
    tbl[6]  = mk(4,  15,  15,   1,   0, 4'b0000, 1'b0,  31,  31, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(4,  15,  15, -16, -16, 4'b0000, 1'b0,  -2,  -2, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1,   7,   0,   0,   0, 4'b0001, 1'b1,   7,   7, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk(3,  -3,  -4,   2,   0, 4'b0000, 1'b1,  -5,  -5, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(4,   1,   2,   3,   4, 4'b0000, 1'b0,  10,  10, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(4,   1,   1,   1,   1, 4'b0000, 1'b0,   4,   4, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    check("rst_out_valid", int'(b8.out_valid), 0);
    check("rst_in_ready", int'(b8.in_ready), 1);
    check("rst_out_acc", $signed(b8.out_acc), 0);
    check("rst_out_count", int'(b8.out_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // Flush with no beat in IDLE must be ignored.
    @(negedge clk);
    b8.flush = 1'b1;
    @(posedge clk);
    #1;
    check("idle_flush_valid", int'(b8.out_valid), 0);
    check("idle_flush_in_ready", int'(b8.in_ready), 1);
    @(negedge clk);
    b8.flush = 1'b0;

    run_vec(tbl[0], 0, 5);
    run_vec(tbl[10], 10, 0);
    for (int k = 1; k < 10; k++) run_vec(tbl[k], k, 0);

    // Flush alone in ACCUM closes a one-beat frame.
    @(negedge clk);
    b8.in_valid = 1'b1;
    b8.in_sum   = 5'd4;
    @(negedge clk);
    b8.in_valid = 1'b0;
    b8.flush    = 1'b1;
    @(posedge clk);
    #1;
    check("accum_flush_valid", int'(b8.out_valid), 1);
    @(negedge clk);
    b8.flush = 1'b0;
    check("accum_flush_acc", $signed(b8.out_acc), 4);
    check("accum_flush_count", int'(b8.out_count), 1);
    b8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("accum_flush_drop", int'(b8.out_valid), 0);
    b8.out_ready = 1'b0;

    // Reset in the middle of a frame discards it.
    @(negedge clk);
    b8.in_valid = 1'b1;
    b8.in_sum   = 5'd5;
    @(negedge clk);
    b8.in_sum   = 5'd6;
    @(negedge clk);
    b8.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_valid", int'(b8.out_valid), 0);
    check("midrst_acc", $signed(b8.out_acc), 0);
    check("midrst_count", int'(b8.out_count), 0);
    check("midrst_sat_ovf", int'({b8.out_sat, b8.out_ovf}), 0);
    check("midrst_in_ready", int'(b8.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_no_result", int'(b8.out_valid), 0);
    run_vec(tbl[11], 11, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
